sobel_edge: RTL and testbench

SOBEL_EDGE -- requirements
Module: sobel_edge

---
 rtl/sobel_edge_if.sv | 26 ++
 rtl/sobel_edge.sv | 153 +++++++++++++++
 tb/tb_sobel_edge.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sobel_edge_if.sv
// Pixel stream in / binary edge stream out for sobel_edge.
// The source drives the pixel side, the edge detector drives the result side.
interface sobel_edge_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] din;
  logic              din_vld;
  logic              din_sop;
  logic              din_eop;
  logic [DATA_W+2:0] thresh;
  logic              dout;
  logic              dout_vld;
  logic              dout_sop;
  logic              dout_eop;
  logic              frame_err;

  modport master (
    output din, din_vld, din_sop, din_eop, thresh,
    input  dout, dout_vld, dout_sop, dout_eop, frame_err
  );

  modport slave (
    input  din, din_vld, din_sop, din_eop, thresh,
    output dout, dout_vld, dout_sop, dout_eop, frame_err
  );
endinterface

// File: rtl/sobel_edge.sv
// Streaming 3x3 Sobel edge detector: two line buffers, |Gx|+|Gy| magnitude,
// threshold compare; two-stage pipeline with border masking and frame checks.
module sobel_edge #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IMG_W  = 640,
  parameter int unsigned IMG_H  = 480,
  parameter bit          INVERT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  sobel_edge_if.slave bus
);

  localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned SUM_W = DATA_W + 2;
  localparam int unsigned MAG_W = DATA_W + 3;

  // Weighted 1-2-1 tap sum of three pixels.
  function automatic logic [SUM_W-1:0] tap3(input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] m,
                                            input logic [DATA_W-1:0] b);
    return SUM_W'(a) + SUM_W'({m, 1'b0}) + SUM_W'(b);
  endfunction

  function automatic logic [SUM_W-1:0] abs_diff(input logic [SUM_W-1:0] a,
                                                input logic [SUM_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // Frame position and state
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             in_frame;
  logic             ovf;

  logic [COL_W-1:0] cur_col;
  logic [COL_W-1:0] nxt_col;
  logic [ROW_W-1:0] cur_row;
  logic [ROW_W-1:0] nxt_row;
  logic             accept;
  logic             at_last_col;
  logic             at_last_row;
  logic             cur_ovf;
  logic             eop_err;
  logic             resync;
  logic             border;

  // Line buffers (top = two lines back, mid = one line back) and column delays
  logic [DATA_W-1:0] lb_top [IMG_W];
  logic [DATA_W-1:0] lb_mid [IMG_W];
  logic [DATA_W-1:0] top_rd, mid_rd;
  logic [DATA_W-1:0] top_d1, top_d2;
  logic [DATA_W-1:0] mid_d1, mid_d2;
  logic [DATA_W-1:0] bot_d1, bot_d2;

  logic [SUM_W-1:0] gx_pos, gx_neg, gy_pos, gy_neg;
  logic [MAG_W-1:0] mag;

  // Stage 1 registers
  logic             s1_vld;
  logic             s1_sop;
  logic             s1_eop;
  logic             s1_err;
  logic             s1_border;
  logic [MAG_W-1:0] s1_mag;
  logic [MAG_W-1:0] s1_thr;

  // Position of the incoming pixel and the counter update it implies
  always_comb begin
    accept      = bus.din_vld && (bus.din_sop || in_frame);
    cur_col     = bus.din_sop ? '0 : col;
    cur_row     = bus.din_sop ? '0 : row;
    cur_ovf     = bus.din_sop ? 1'b0 : ovf;
    at_last_col = (cur_col == COL_W'(IMG_W - 1));
    at_last_row = (cur_row == ROW_W'(IMG_H - 1));
    nxt_col     = at_last_col ? '0 : cur_col + COL_W'(1);
    nxt_row     = (at_last_col && !at_last_row) ? cur_row + ROW_W'(1) : cur_row;
    eop_err     = !(at_last_col && at_last_row) || cur_ovf;
    resync      = accept && bus.din_sop && in_frame;
    border      = (cur_row < ROW_W'(2)) || (cur_col < COL_W'(2));
  end

  // Window: newest column comes straight from the line buffers and din
  always_comb begin
    top_rd = lb_top[cur_col];
    mid_rd = lb_mid[cur_col];
    gx_pos = tap3(top_rd, mid_rd, bus.din);
    gx_neg = tap3(top_d2, mid_d2, bot_d2);
    gy_pos = tap3(top_d2, top_d1, top_rd);
    gy_neg = tap3(bot_d2, bot_d1, bus.din);
    mag    = MAG_W'(abs_diff(gx_pos, gx_neg)) + MAG_W'(abs_diff(gy_pos, gy_neg));
  end

  // Pixel storage needs no reset; stale data only reaches border-masked outputs
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_top[cur_col] <= mid_rd;
      lb_mid[cur_col] <= bus.din;
      top_d1 <= top_rd;
      top_d2 <= top_d1;
      mid_d1 <= mid_rd;
      mid_d2 <= mid_d1;
      bot_d1 <= bus.din;
      bot_d2 <= bot_d1;
    end
  end

  // Counters, frame tracking and the two pipeline stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col           <= '0;
      row           <= '0;
      in_frame      <= 1'b0;
      ovf           <= 1'b0;
      s1_vld        <= 1'b0;
      s1_sop        <= 1'b0;
      s1_eop        <= 1'b0;
      s1_err        <= 1'b0;
      s1_border     <= 1'b1;
      s1_mag        <= '0;
      s1_thr        <= '0;
      bus.dout      <= 1'b0;
      bus.dout_vld  <= 1'b0;
      bus.dout_sop  <= 1'b0;
      bus.dout_eop  <= 1'b0;
      bus.frame_err <= 1'b0;
    end else begin
      if (accept) begin
        col      <= bus.din_eop ? '0 : nxt_col;
        row      <= bus.din_eop ? '0 : nxt_row;
        in_frame <= !bus.din_eop;
        // Sticky once the frame runs past the last pixel (row saturated)
        ovf      <= !bus.din_eop && (cur_ovf || (at_last_col && at_last_row));
      end
      s1_vld    <= accept;
      s1_sop    <= accept && bus.din_sop;
      s1_eop    <= accept && bus.din_eop;
      s1_err    <= accept && bus.din_eop && eop_err;
      s1_border <= border;
      s1_mag    <= mag;
      s1_thr    <= bus.thresh;

      bus.dout_vld  <= s1_vld;
      bus.dout_sop  <= s1_sop;
      bus.dout_eop  <= s1_eop;
      bus.dout      <= s1_vld && ((!s1_border && (s1_mag > s1_thr)) ^ INVERT);
      // A resync sop flags the pixel still in stage 1 (the last pre-sop pixel)
      bus.frame_err <= s1_err || resync;
    end
  end

endmodule

// File: tb/tb_sobel_edge.sv
// Randomized scoreboard bench for sobel_edge against a frame-array Sobel model.
module tb_sobel_edge;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned IMG_W  = 8;
  localparam int unsigned IMG_H  = 6;
  localparam int unsigned TH_W   = DATA_W + 3;
  localparam bit          INVERT = 1'b1;

  typedef struct {
    logic   dout;
    logic   sop;
    logic   eop;
    logic   err;
    longint due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  sobel_edge_if #(.DATA_W(DATA_W)) bus ();

  sobel_edge #(
    .DATA_W(DATA_W),
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .INVERT(INVERT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  int m_img [IMG_H][IMG_W];
  bit m_in = 1'b0;
  int m_r = 0;
  int m_c = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, req, $time);
    end
  endtask

  function automatic int px(input int r, input int c);
    return m_img[r][c];
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference: place pixel in the frame image, Sobel on the 3x3 ending at it
  task automatic model(input int pix, input bit sop, input bit eop, input int thr, input longint t);
    exp_t e;
    exp_t last;
    int   gx;
    int   gy;
    bit   edge_b;
    if (sop) begin
      if (m_in && exp_q.size() > 0) begin
        last = exp_q.pop_back();
        last.err = 1'b1;
        exp_q.push_back(last);
      end
      m_in = 1'b1;
      m_r  = 0;
      m_c  = 0;
    end
    if (!m_in) return;
    m_img[m_r][m_c] = pix;
    edge_b = 1'b0;
    if (m_r >= 2 && m_c >= 2) begin
      gx = (px(m_r-2, m_c) + 2*px(m_r-1, m_c) + px(m_r, m_c))
         - (px(m_r-2, m_c-2) + 2*px(m_r-1, m_c-2) + px(m_r, m_c-2));
      gy = (px(m_r-2, m_c-2) + 2*px(m_r-2, m_c-1) + px(m_r-2, m_c))
         - (px(m_r, m_c-2) + 2*px(m_r, m_c-1) + px(m_r, m_c));
      edge_b = (iabs(gx) + iabs(gy)) > thr;
    end
    e.dout = edge_b ^ INVERT;
    e.sop  = sop;
    e.eop  = eop;
    e.err  = eop && !(m_r == IMG_H-1 && m_c == IMG_W-1);
    e.due  = t + 15;
    exp_q.push_back(e);
    if (eop) begin
      m_in = 1'b0;
      m_r  = 0;
      m_c  = 0;
    end else if (m_c == IMG_W-1) begin
      m_c = 0;
      if (m_r < IMG_H-1) m_r++;
    end else begin
      m_c++;
    end
  endtask

  task automatic send(input int pix, input bit sop, input bit eop, input int thr);
    @(negedge clk);
    bus.din     = DATA_W'(pix);
    bus.din_vld = 1'b1;
    bus.din_sop = sop;
    bus.din_eop = eop;
    bus.thresh  = TH_W'(thr);
    @(posedge clk);
    model(pix, sop, eop, thr, $time);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.din_vld = 1'b0;
      bus.din_sop = 1'b0;
      bus.din_eop = 1'b0;
      bus.din     = DATA_W'($urandom);
      bus.thresh  = TH_W'($urandom);
    end
  endtask

  // kind: 0 = constant 100, 1 = left half 0 / right half 255, 2 = random
  task automatic frame(input int kind, input int thr, input bit gaps, input int len,
                       input bit with_eop);
    int pix;
    for (int i = 0; i < len; i++) begin
      case (kind)
        0:       pix = 100;
        1:       pix = ((i % IMG_W) >= 4) ? 255 : 0;
        default: pix = int'($urandom_range(0, 255));
      endcase
      if (gaps) idle(int'($urandom_range(0, 2)));
      send(pix, i == 0, with_eop && (i == len-1), thr);
    end
  endtask

  task automatic drain(input string name);
    idle(4);
    check(name, exp_q.size(), 0);
  endtask

  // Scoreboard monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.dout_vld) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got dout_vld=1 expected no output at t=%0t", $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("dout", bus.dout, mon_e.dout);
          check("dout_sop", bus.dout_sop, mon_e.sop);
          check("dout_eop", bus.dout_eop, mon_e.eop);
          check("frame_err", bus.frame_err, mon_e.err);
          check("latency_time", $time, mon_e.due);
        end
      end else begin
        check("idle_flags", {bus.dout_sop, bus.dout_eop, bus.frame_err}, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  localparam int FRAME_LEN = IMG_W * IMG_H;

  initial begin
    bus.din     = '0;
    bus.din_vld = 1'b0;
    bus.din_sop = 1'b0;
    bus.din_eop = 1'b0;
    bus.thresh  = '0;
    repeat (3) @(negedge clk);
    check("reset_dout_vld", bus.dout_vld, 0);
    check("reset_dout", bus.dout, 0);
    check("reset_frame_err", bus.frame_err, 0);
    rst_n = 1'b1;

    // Pixels before any sop are dropped
    for (int i = 0; i < 5; i++) send(int'($urandom_range(0, 255)), 1'b0, i == 4, 10);
    drain("presop_drain");

    frame(0, 10, 1'b0, FRAME_LEN, 1'b1);
    drain("const_drain");
    frame(1, 100, 1'b0, FRAME_LEN, 1'b1);
    drain("step_drain");
    frame(1, 100, 1'b1, FRAME_LEN, 1'b1);
    drain("step_gaps_drain");

    // Threshold boundary on mag = 1020
    frame(1, 1020, 1'b0, FRAME_LEN, 1'b1);
    frame(1, 1019, 1'b0, FRAME_LEN, 1'b1);
    drain("thresh_drain");

    // Early eop, trailing non-sop pixels ignored, then a clean frame
    frame(2, 200, 1'b0, 20, 1'b1);
    for (int i = 0; i < 5; i++) send(int'($urandom_range(0, 255)), 1'b0, 1'b0, 10);
    frame(2, 300, 1'b1, FRAME_LEN, 1'b1);
    drain("short_frame_drain");

    // One-pixel frame
    send(50, 1'b1, 1'b1, 10);
    drain("single_drain");

    // Back-to-back sop before eop resynchronises the frame
    frame(2, 250, 1'b0, 10, 1'b0);
    frame(2, 250, 1'b0, FRAME_LEN, 1'b1);
    drain("resync_drain");

    // Reset mid-frame at pixel 30
    frame(0, 10, 1'b0, 30, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    bus.din_vld = 1'b0;
    exp_q.delete();
    m_in = 1'b0;
    m_r  = 0;
    m_c  = 0;
    #1;
    check("midrst_dout_vld", bus.dout_vld, 0);
    check("midrst_dout", bus.dout, 0);
    check("midrst_sop", bus.dout_sop, 0);
    check("midrst_eop", bus.dout_eop, 0);
    check("midrst_frame_err", bus.frame_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) send(100, 1'b0, 1'b0, 10);
    drain("postrst_nosop_drain");
    frame(0, 10, 1'b0, FRAME_LEN, 1'b1);
    drain("postrst_frame_drain");

    // Random frames, thresholds and gaps
    for (int f = 0; f < 6; f++) begin
      frame(2, int'($urandom_range(0, 700)), f[0], FRAME_LEN, 1'b1);
    end
    drain("random_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
